frame_capture_buffer: RTL and testbench



---
 rtl/frame_capture_buffer_pkg.sv | 22 ++
 rtl/frame_capture_buffer_sdpram.sv | 41 ++++
 rtl/frame_capture_buffer.sv | 106 ++++++++++
 tb/tb_frame_capture_buffer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/frame_capture_buffer_pkg.sv
// Shared types and width helpers for the frame capture buffer.
package frame_capture_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  function automatic int bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic int idx_w(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

  function automatic int addr_w(input int num_banks, input int frame_len);
    return bank_w(num_banks) + idx_w(frame_len);
  endfunction

endpackage

// File: rtl/frame_capture_buffer_sdpram.sv
// Single-clock simple dual-port RAM; read latency 1, or 2 with OUTPUT_REG=1.
module frame_capture_sdpram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 10,
  parameter int OUTPUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_W];
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else     rd_q <= mem[raddr];
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] rd_q2;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_q2 <= '0;
        else     rd_q2 <= rd_q;
      end
      assign rdata = rd_q2;
    end else begin : g_noreg
      assign rdata = rd_q;
    end
  endgenerate

endmodule

// File: rtl/frame_capture_buffer.sv
// Multi-bank frame capture buffer: fills banks in rotation, hands full frames out in order.
// Optional drop_count/frames_pending outputs under FRAME_CAPTURE_BUFFER_STATS_EN.
module frame_capture_buffer
  import frame_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 512,
  parameter int NUM_BANKS  = 2,
  parameter int OUTPUT_REG = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          frame_valid,
  output logic [bank_w(NUM_BANKS)-1:0]  frame_bank,
  input  logic [idx_w(FRAME_LEN)-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data,
  input  logic                          frame_release,
  output logic                          overflow
`ifdef FRAME_CAPTURE_BUFFER_STATS_EN
  ,
  output logic [15:0]                   drop_count,
  output logic [bank_w(NUM_BANKS):0]    frames_pending
`endif
);

  localparam int BANK_W = bank_w(NUM_BANKS);
  localparam int IDX_W  = idx_w(FRAME_LEN);
  localparam int ADDR_W = addr_w(NUM_BANKS, FRAME_LEN);

  bank_state_t       bank_st [NUM_BANKS];
  logic [BANK_W-1:0] wr_bank, rd_bank, wr_bank_nxt, rd_bank_nxt;
  logic [IDX_W-1:0]  wr_idx;
  logic              rel_gap;
  logic              wr_ok, drop, release_ok, last_sample;

  assign wr_ok       = in_valid && (bank_st[wr_bank] != FULL);
  assign drop        = in_valid && (bank_st[wr_bank] == FULL);
  assign last_sample = (wr_idx == IDX_W'(FRAME_LEN - 1));
  assign wr_bank_nxt = (wr_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : wr_bank + 1'b1;
  assign rd_bank_nxt = (rd_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : rd_bank + 1'b1;

  // rel_gap forces one idle cycle between consecutive frames.
  assign frame_valid = (bank_st[rd_bank] == FULL) && !rel_gap;
  assign frame_bank  = rd_bank;
  assign release_ok  = frame_release && frame_valid;

  // A write needs a non-FULL bank and a release needs a FULL one, so the two
  // never update the same bank state in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) bank_st[i] <= FREE;
      wr_bank  <= '0;
      rd_bank  <= '0;
      wr_idx   <= '0;
      rel_gap  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        if (last_sample) begin
          bank_st[wr_bank] <= FULL;
          wr_idx           <= '0;
          wr_bank          <= wr_bank_nxt;
        end else begin
          bank_st[wr_bank] <= FILLING;
          wr_idx           <= wr_idx + 1'b1;
        end
      end
      if (drop) overflow <= 1'b1;
      if (release_ok) begin
        bank_st[rd_bank] <= FREE;
        rd_bank          <= rd_bank_nxt;
      end
      rel_gap <= release_ok;
    end
  end

  frame_capture_sdpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W),
    .OUTPUT_REG (OUTPUT_REG)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr ({wr_bank, wr_idx}),
    .wdata (in_data),
    .raddr ({rd_bank, rd_addr}),
    .rdata (rd_data)
  );

`ifdef FRAME_CAPTURE_BUFFER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end

  always_comb begin
    frames_pending = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (bank_st[i] == FULL) frames_pending = frames_pending + 1'b1;
  end
`endif

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Scoreboard bench for frame_capture_buffer with a queue-of-frames reference model.
module tb_frame_capture_buffer;

  localparam int DW   = 16;
  localparam int FL   = 16;
  localparam int NB   = 2;
  localparam int OREG = 0;
  localparam int LAT  = 1 + OREG;

  typedef struct {
    bit          chk;
    logic [15:0] val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          frame_valid;
  logic [0:0]    frame_bank;
  logic [3:0]    rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          frame_release = 1'b0;
  logic          overflow;
`ifdef FRAME_CAPTURE_BUFFER_STATS_EN
  logic [15:0]   drop_count;
  logic [1:0]    frames_pending;
`endif

  frame_capture_buffer #(
    .DATA_WIDTH (DW),
    .FRAME_LEN  (FL),
    .NUM_BANKS  (NB),
    .OUTPUT_REG (OREG)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .frame_valid   (frame_valid),
    .frame_bank    (frame_bank),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .frame_release (frame_release),
    .overflow      (overflow)
`ifdef FRAME_CAPTURE_BUFFER_STATS_EN
    ,
    .drop_count     (drop_count),
    .frames_pending (frames_pending)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of completed (unreleased) banks in arrival order.
  int          full_q[$];
  int          m_wr_bank, m_wr_idx, m_rd_ptr, m_drops;
  bit          m_gap, m_ovf;
  logic [15:0] m_mem [NB][FL];
  exp_t        exp_q[$];
  exp_t        pipe [LAT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_valid();
    return (full_q.size() > 0) && !m_gap;
  endfunction

  task automatic model_reset();
    full_q.delete();
    exp_q.delete();
    m_wr_bank = 0; m_wr_idx = 0; m_rd_ptr = 0; m_drops = 0;
    m_gap = 0; m_ovf = 0;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < FL; i++) m_mem[b][i] = 'x;
  endtask

  task automatic step(input bit v, input logic [15:0] d, input bit rel, input int a);
    bit mv, busy;
    @(negedge clk);
    mv = m_valid();
    chk("frame_valid", frame_valid, mv);
    chk("frame_bank", frame_bank, m_rd_ptr);
    chk("overflow", overflow, m_ovf);
`ifdef FRAME_CAPTURE_BUFFER_STATS_EN
    chk("drop_count", drop_count, m_drops);
    chk("frames_pending", frames_pending, full_q.size());
`endif
    in_valid = v; in_data = d; frame_release = rel; rd_addr = a[3:0];
    exp_q.push_back('{chk: mv, val: m_mem[m_rd_ptr][a[3:0]]});
    busy = 0;
    foreach (full_q[i]) if (full_q[i] == m_wr_bank) busy = 1;
    if (v && busy) begin
      m_ovf = 1;
      if (m_drops < 65535) m_drops++;
    end
    if (v && !busy) begin
      m_mem[m_wr_bank][m_wr_idx] = d;
      m_wr_idx++;
      if (m_wr_idx == FL) begin
        m_wr_idx = 0;
        full_q.push_back(m_wr_bank);
        m_wr_bank = (m_wr_bank + 1) % NB;
      end
    end
    if (rel && mv) begin
      void'(full_q.pop_front());
      m_rd_ptr = (m_rd_ptr + 1) % NB;
    end
    m_gap = rel && mv;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    in_valid = 0; frame_release = 0; in_data = '0; rd_addr = '0;
    model_reset();
    #1;
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_frame_bank", frame_bank, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: collects the expected read word for each issued rd_addr and
  // compares once the read latency has elapsed.
  initial begin
    for (int i = 0; i < LAT; i++) pipe[i] = '{chk: 0, val: '0};
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < LAT; i++) pipe[i] = '{chk: 0, val: '0};
      end else begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        if (exp_q.size() > 0) pipe[0] = exp_q.pop_front();
        else                  pipe[0] = '{chk: 0, val: '0};
      end
      @(negedge clk);
      if (!rst && pipe[LAT-1].chk) chk("rd_data", rd_data, pipe[LAT-1].val);
    end
  end

  initial begin
    model_reset();
    do_reset();

    // Frame 0 from samples 0..15, then read it back in order.
    for (int i = 0; i < 16; i++) step(1, 16'(i), 0, 0);
    for (int i = 0; i < 16; i++) step(0, '0, 0, i);

    // Fill bank 1, overflow on the next sample, release bank 0 and refill it.
    for (int i = 16; i < 32; i++) step(1, 16'(i), 0, $urandom_range(15));
    step(1, 16'd32, 0, 0);
    step(0, '0, 0, 3);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 16'(100 + i), 0, i);
    step(0, '0, 1, 0);
    for (int i = 0; i < 18; i++) step(0, '0, 0, i % 16);

    // Same-cycle release of bank 0 with a write aimed at bank 0.
    do_reset();
    for (int i = 0; i < 32; i++) step(1, 16'(i + 200), 0, 0);
    step(1, 16'h5555, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 16'(16'hA000 + i), 0, 0);
    step(0, '0, 1, 0);
    for (int i = 0; i < 18; i++) step(0, '0, 0, i % 16);

    // Reset in the middle of a frame.
    for (int i = 0; i < 8; i++) step(1, 16'(i), 0, 0);
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 16'(16'h3000 + i), 0, 0);
    for (int i = 0; i < 16; i++) step(0, '0, 0, i);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++)
      step($urandom_range(99) < 70, 16'($urandom), $urandom_range(99) < 12,
           $urandom_range(15));
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
